// File: rtl/mem_word_streamer.sv
// Walks NUM_WORDS ROM addresses per start and re-times the 2-cycle ROM output into a valid/ready stream.
// Define MEM_STREAM_REVERSE_EN for descending (most-significant-word-first) addresses.
module mem_word_streamer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_WORDS  = 128
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [WIDTH-1:0]      i_mem_data,
  output logic [WIDTH-1:0]      o_word_out,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  output logic [ADDR_WIDTH:0]   o_word_idx,
  output logic                  o_word_last,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int                    CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         LP_N    = CW'(NUM_WORDS);
  localparam logic [CW-1:0]         LP_LAST = CW'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_SPAN = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;
  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [CW-1:0]         r_issue_cnt;
  logic [CW-1:0]         r_word_idx;
  logic                  r_addr_vld;
  logic [1:0]            r_inflight;
  logic [WIDTH-1:0]      r_fifo [4];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_count;

  logic                  w_start;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_credit;
  logic [2:0]            w_tokens;
  logic [ADDR_WIDTH-1:0] w_first_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;

`ifdef MEM_STREAM_REVERSE_EN
  assign w_first_addr = i_base_addr + LP_SPAN;
  assign w_next_addr  = r_mem_addr - 1'b1;
`else
  assign w_first_addr = i_base_addr;
  assign w_next_addr  = r_mem_addr + 1'b1;
`endif

  // Every read occupies a slot from issue until its word leaves the FIFO; a pop this cycle frees one.
  assign w_tokens = {2'b00, r_addr_vld} + {2'b00, r_inflight[0]} + {2'b00, r_inflight[1]} + r_count;
  assign w_credit = (w_tokens < 3'd4) || (w_pop && (w_tokens == 3'd4));

  assign w_valid  = (r_count != 3'd0);
  assign w_pop    = w_valid && i_word_ready;
  assign w_push   = r_inflight[1];
  assign w_start  = (r_state == S_IDLE) && i_start;
  assign w_issue  = (r_state == S_ISSUE) && (r_issue_cnt != LP_N) && w_credit;

  assign o_mem_addr   = r_mem_addr;
  assign o_word_valid = w_valid;
  assign o_word_out   = w_valid ? r_fifo[r_rd_ptr] : '0;
  assign o_word_idx   = r_word_idx;
  assign o_word_last  = w_valid && (r_word_idx == LP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: if (r_issue_cnt == LP_N) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && o_word_last) w_state_nxt = S_FIN;
      S_FIN: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= '0;
      r_issue_cnt <= '0;
      r_word_idx  <= '0;
      r_addr_vld  <= 1'b0;
      r_inflight  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr_vld <= w_start || w_issue;
      r_inflight <= {r_inflight[0], r_addr_vld};
      if (w_start) begin
        r_mem_addr  <= w_first_addr;
        r_issue_cnt <= CW'(1);
        r_word_idx  <= '0;
      end else begin
        if (w_issue) begin
          r_mem_addr  <= w_next_addr;
          r_issue_cnt <= r_issue_cnt + 1'b1;
        end
        if (w_pop) r_word_idx <= r_word_idx + 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_mem_data;
  end

endmodule

// File: tb/tb_mem_word_streamer.sv
// Bench: a 128-word instance (main runs, stalls, reset) and a 4-word instance (address-wrap vector table).
`timescale 1ns/1ps
module tb_mem_word_streamer;
  localparam int W  = 32;
  localparam int AW = 7;
  localparam int NA = 128;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, a_start, b_start, ready, sel;
  logic [AW-1:0] base;
  logic [AW-1:0] a_mem_addr, b_mem_addr, a_rom_q, b_rom_q;
  logic [W-1:0]  a_mem_data, b_mem_data, a_out, b_out;
  logic [AW:0]   a_idx, b_idx;
  logic          a_valid, b_valid, a_last, b_last, a_busy, b_busy, a_done, b_done;

  mem_word_streamer #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_WORDS(NA)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_base_addr(base),
    .o_mem_addr(a_mem_addr), .i_mem_data(a_mem_data), .o_word_out(a_out),
    .o_word_valid(a_valid), .i_word_ready(ready), .o_word_idx(a_idx),
    .o_word_last(a_last), .o_busy(a_busy), .o_done(a_done));

  mem_word_streamer #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_WORDS(NB)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_base_addr(base),
    .o_mem_addr(b_mem_addr), .i_mem_data(b_mem_data), .o_word_out(b_out),
    .o_word_valid(b_valid), .i_word_ready(ready), .o_word_idx(b_idx),
    .o_word_last(b_last), .o_busy(b_busy), .o_done(b_done));

  // ROM models: registered address then registered output, word[i] = i.
  always @(posedge clk) begin
    a_rom_q    <= a_mem_addr;
    b_rom_q    <= b_mem_addr;
    a_mem_data <= W'(a_rom_q);
    b_mem_data <= W'(b_rom_q);
  end

  logic [AW-1:0] m_mem_addr;
  logic [W-1:0]  m_out;
  logic [AW:0]   m_idx;
  logic          m_valid, m_last, m_busy, m_done;
  assign m_mem_addr = sel ? b_mem_addr : a_mem_addr;
  assign m_out      = sel ? b_out      : a_out;
  assign m_idx      = sel ? b_idx      : a_idx;
  assign m_valid    = sel ? b_valid    : a_valid;
  assign m_last     = sel ? b_last     : a_last;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_done     = sel ? b_done     : a_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0]       base;
    int                  stall;
    logic [3:0][AW-1:0]  exp;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_a(input logic [AW-1:0] b, input int k);
    logic [AW-1:0] kk;
    kk = AW'(k);
`ifdef MEM_STREAM_REVERSE_EN
    return b + AW'(NA - 1) - kk;
`else
    return b + kk;
`endif
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_mem_addr"}, 64'(m_mem_addr), 64'(0));
    chk({tag, "_word_out"}, 64'(m_out), 64'(0));
    chk({tag, "_valid"},    64'(m_valid), 64'(0));
    chk({tag, "_idx"},      64'(m_idx), 64'(0));
    chk({tag, "_last"},     64'(m_last), 64'(0));
    chk({tag, "_busy"},     64'(m_busy), 64'(0));
    chk({tag, "_done"},     64'(m_done), 64'(0));
  endtask

  // One complete run: s selects the 4-word instance (expected addresses from e4).
  task automatic run_stream(input bit s, input logic [AW-1:0] b, input int stall,
                            input int restart_at, input logic [3:0][AW-1:0] e4);
    int            n, cyc, k;
    bit            first;
    logic [AW-1:0] ea, prev;
    logic [AW-1:0] seen[$];
    n     = s ? NB : NA;
    sel   = s;
    base  = b;
    ready = 1'b1;
    if (s) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
    ea = s ? e4[0] : addr_a(b, 0);
    chk("first_mem_addr", 64'(m_mem_addr), 64'(ea));
    chk("busy_after_start", 64'(m_busy), 64'(1));
    seen.push_back(m_mem_addr);
    prev  = m_mem_addr;
    cyc   = 0;
    k     = 0;
    first = 1'b1;
    while (k < n && cyc < 2000) begin
      if (m_mem_addr != prev) begin
        seen.push_back(m_mem_addr);
        prev = m_mem_addr;
      end
      ready = (stall == 0) ? 1'b1 : ((cyc % stall) != 0);
      if (restart_at == cyc) begin
        if (s) b_start = 1'b1; else a_start = 1'b1;
        base = b + 7'h33;
      end else begin
        a_start = 1'b0;
        b_start = 1'b0;
      end
      if (m_valid) begin
        ea = s ? e4[k] : addr_a(b, k);
        chk($sformatf("word[%0d]", k), 64'({m_out, m_idx, m_last}),
            64'({W'(ea), 8'(k), (k == n - 1)}));
        if (first) begin
          chk("first_valid_latency", 64'(cyc), 64'(3));
          first = 1'b0;
        end
        if (ready) k++;
      end else if (!first && stall == 0) begin
        chk("no_gap", 64'(m_valid), 64'(1));
      end
      if (m_done) chk("early_done", 64'(m_done), 64'(0));
      @(posedge clk); #1;
      cyc++;
    end
    a_start = 1'b0;
    b_start = 1'b0;
    chk("run_completed", 64'(k), 64'(n));
    if (k == n) begin
      chk("done_pulse", 64'(m_done), 64'(1));
      chk("busy_in_fin", 64'(m_busy), 64'(1));
      chk("valid_after_last", 64'(m_valid), 64'(0));
      @(posedge clk); #1;
      chk("done_fell", 64'(m_done), 64'(0));
      chk("busy_fell", 64'(m_busy), 64'(0));
    end
    if (s) begin
      chk("addr_count", 64'(seen.size()), 64'(4));
      for (int i = 0; i < 4 && i < seen.size(); i++)
        chk($sformatf("addr_seq[%0d]", i), 64'(seen[i]), 64'(e4[i]));
    end
  endtask

  initial begin
`ifdef MEM_STREAM_REVERSE_EN
    tbl[0] = '{base: 7'h7E, stall: 0, exp: {7'h7E, 7'h7F, 7'h00, 7'h01}};
    tbl[1] = '{base: 7'h00, stall: 3, exp: {7'h00, 7'h01, 7'h02, 7'h03}};
    tbl[2] = '{base: 7'h7F, stall: 2, exp: {7'h7F, 7'h00, 7'h01, 7'h02}};
`else
    tbl[0] = '{base: 7'h7E, stall: 0, exp: {7'h01, 7'h00, 7'h7F, 7'h7E}};
    tbl[1] = '{base: 7'h00, stall: 3, exp: {7'h03, 7'h02, 7'h01, 7'h00}};
    tbl[2] = '{base: 7'h7F, stall: 2, exp: {7'h02, 7'h01, 7'h00, 7'h7F}};
`endif
    rst     = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    base    = '0;
    ready   = 1'b1;
    sel     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_a");
    sel = 1'b1; #1;
    check_reset("rst_b");
    sel = 1'b0;
    rst = 1'b0;

    run_stream(1'b0, 7'h00, 0, -1, '0);
    run_stream(1'b0, 7'h40, 3, -1, '0);
    run_stream(1'b0, 7'h05, 0, 10, '0);
    run_stream(1'b0, 7'h7E, 0, -1, '0);

    // Reset with two reads in flight and two words held in the FIFO.
    sel     = 1'b0;
    ready   = 1'b0;
    base    = 7'h05;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("prereset_valid", 64'(a_valid), 64'(1));
    chk("prereset_word", 64'(a_out), 64'(addr_a(7'h05, 0)));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("midrun_rst");
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", 64'({a_valid, a_busy}), 64'(0));
    end
    run_stream(1'b0, 7'h20, 0, -1, '0);

    for (int i = 0; i < 3; i++)
      run_stream(1'b1, tbl[i].base, tbl[i].stall, -1, tbl[i].exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
